// File: rtl/intersection_phase_scheduler_pkg.sv
// Shared types and timing defaults for the intersection phase scheduler.
// Phase encodings double as the externally visible 'phase' status value.
package tlc_pkg;

    typedef enum logic [2:0] {
        AR_TO_NS  = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        AR_TO_EW  = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5
    } phase_t;

    localparam int DEF_MIN_GREEN  = 8;
    localparam int DEF_MAX_GREEN  = 32;
    localparam int DEF_YELLOW_CYC = 4;
    localparam int DEF_ALLRED_CYC = 2;
    localparam int DEF_WALK_CYC   = 6;

    // Counter width wide enough for the largest interval, never below one bit.
    function automatic int timer_width(input int a, input int b, input int c,
                                       input int d, input int e);
        int m;
        int w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        w = (m < 2) ? 1 : $clog2(m);
        return w;
    endfunction

endpackage

// File: rtl/intersection_phase_scheduler_timer.sv
// Phase interval timer: cleared on state entry, saturating up-count, and a
// compare against the terminal value of the current state.
module phase_timer #(
    parameter int WIDTH = 5,
    parameter int SAT   = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] count,
    output logic             at_term
);

    localparam logic [WIDTH-1:0] SAT_V = WIDTH'(SAT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (count != SAT_V)
            count <= count + 1'b1;
    end

    assign at_term = (count == term);

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Actuated two-approach (NS/EW) signal phase scheduler with pedestrian WALK.
// Optional emergency preemption is compiled in when PREEMPT_EN is defined.
module intersection_phase_scheduler
    import tlc_pkg::*;
#(
    parameter int MIN_GREEN  = DEF_MIN_GREEN,
    parameter int MAX_GREEN  = DEF_MAX_GREEN,
    parameter int YELLOW_CYC = DEF_YELLOW_CYC,
    parameter int ALLRED_CYC = DEF_ALLRED_CYC,
    parameter int WALK_CYC   = DEF_WALK_CYC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ns_veh,
    input  logic       ew_veh,
    input  logic       ns_ped,
    input  logic       ew_ped,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       ns_walk,
    output logic       ew_walk,
    output logic [2:0] phase,
    output logic       phase_change
`ifdef PREEMPT_EN
    ,
    input  logic       preempt,
    input  logic       preempt_dir
`endif
);

    localparam int TW = timer_width(MIN_GREEN, MAX_GREEN, YELLOW_CYC, ALLRED_CYC, WALK_CYC);

    localparam logic [TW-1:0] MIN_T = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] MAX_T = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] YEL_T = TW'(YELLOW_CYC - 1);
    localparam logic [TW-1:0] AR_T  = TW'(ALLRED_CYC - 1);

    phase_t        state;
    phase_t        next_state;
    logic [TW-1:0] timer;
    logic [TW-1:0] term_val;
    logic          at_term;
    logic          timer_clear;
    logic          ns_veh_q, ns_ped_q, ew_veh_q, ew_ped_q;
    logic          ns_walk_armed, ew_walk_armed;
    logic          ns_enter, ew_enter;
    logic          pre_ns, pre_ew;

`ifdef PREEMPT_EN
    assign pre_ns = preempt & ~preempt_dir;
    assign pre_ew = preempt &  preempt_dir;
`else
    assign pre_ns = 1'b0;
    assign pre_ew = 1'b0;
`endif

    phase_timer #(
        .WIDTH (TW),
        .SAT   (MAX_GREEN - 1)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .term    (term_val),
        .count   (timer),
        .at_term (at_term)
    );

    // Green exit needs min green, opposing demand, and either a gap in own
    // traffic or max-out; preemption overrides both min green and demand.
    always_comb begin
        next_state = state;
        term_val   = MAX_T;
        case (state)
            AR_TO_NS: begin
                term_val = AR_T;
                if (at_term) next_state = NS_GREEN;
            end
            NS_GREEN: begin
                term_val = MAX_T;
                if (pre_ew)
                    next_state = NS_YELLOW;
                else if (!pre_ns && (timer >= MIN_T) && (ew_veh_q | ew_ped_q) &&
                         (!ns_veh || at_term))
                    next_state = NS_YELLOW;
            end
            NS_YELLOW: begin
                term_val = YEL_T;
                if (at_term) next_state = AR_TO_EW;
            end
            AR_TO_EW: begin
                term_val = AR_T;
                if (at_term) next_state = EW_GREEN;
            end
            EW_GREEN: begin
                term_val = MAX_T;
                if (pre_ns)
                    next_state = EW_YELLOW;
                else if (!pre_ew && (timer >= MIN_T) && (ns_veh_q | ns_ped_q) &&
                         (!ew_veh || at_term))
                    next_state = EW_YELLOW;
            end
            EW_YELLOW: begin
                term_val = YEL_T;
                if (at_term) next_state = AR_TO_NS;
            end
            default: next_state = AR_TO_NS;
        endcase
    end

    assign timer_clear = (next_state != state);
    assign ns_enter    = (next_state == NS_GREEN) && (state != NS_GREEN);
    assign ew_enter    = (next_state == EW_GREEN) && (state != EW_GREEN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= AR_TO_NS;
            phase        <= 3'd0;
            phase_change <= 1'b0;
            ns_red       <= 1'b1;
            ns_yellow    <= 1'b0;
            ns_green     <= 1'b0;
            ew_red       <= 1'b1;
            ew_yellow    <= 1'b0;
            ew_green     <= 1'b0;
        end else begin
            state        <= next_state;
            phase        <= next_state;
            phase_change <= timer_clear;
            ns_green     <= (next_state == NS_GREEN);
            ns_yellow    <= (next_state == NS_YELLOW);
            ns_red       <= (next_state != NS_GREEN) && (next_state != NS_YELLOW);
            ew_green     <= (next_state == EW_GREEN);
            ew_yellow    <= (next_state == EW_YELLOW);
            ew_red       <= (next_state != EW_GREEN) && (next_state != EW_YELLOW);
        end
    end

    // Requests latch only while their approach is red/yellow; entering green
    // consumes them, and the pedestrian latch at that moment arms WALK.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ns_veh_q      <= 1'b0;
            ns_ped_q      <= 1'b0;
            ew_veh_q      <= 1'b0;
            ew_ped_q      <= 1'b0;
            ns_walk_armed <= 1'b0;
            ew_walk_armed <= 1'b0;
        end else begin
            if (ns_enter) begin
                ns_veh_q      <= 1'b0;
                ns_ped_q      <= 1'b0;
                ns_walk_armed <= ns_ped_q;
            end else if (state != NS_GREEN) begin
                if (ns_veh) ns_veh_q <= 1'b1;
                if (ns_ped) ns_ped_q <= 1'b1;
            end
            if (ew_enter) begin
                ew_veh_q      <= 1'b0;
                ew_ped_q      <= 1'b0;
                ew_walk_armed <= ew_ped_q;
            end else if (state != EW_GREEN) begin
                if (ew_veh) ew_veh_q <= 1'b1;
                if (ew_ped) ew_ped_q <= 1'b1;
            end
        end
    end

    assign ns_walk = (state == NS_GREEN) && ns_walk_armed && (int'(timer) < WALK_CYC);
    assign ew_walk = (state == EW_GREEN) && ew_walk_armed && (int'(timer) < WALK_CYC);

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed self-checking bench for intersection_phase_scheduler (default timing).
// Define PREEMPT_EN to also exercise the preemption ports.
module tb_intersection_phase_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       ns_veh, ew_veh, ns_ped, ew_ped;
    logic       ns_red, ns_yellow, ns_green;
    logic       ew_red, ew_yellow, ew_green;
    logic       ns_walk, ew_walk;
    logic [2:0] phase;
    logic       phase_change;
`ifdef PREEMPT_EN
    logic       preempt;
    logic       preempt_dir;
`endif

    int errors = 0;
    int checks = 0;
    int pc_cnt = 0;
    int ns_walk_seen = 0;
    int cyc;
    int bad;

    intersection_phase_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .ns_veh       (ns_veh),
        .ew_veh       (ew_veh),
        .ns_ped       (ns_ped),
        .ew_ped       (ew_ped),
        .ns_red       (ns_red),
        .ns_yellow    (ns_yellow),
        .ns_green     (ns_green),
        .ew_red       (ew_red),
        .ew_yellow    (ew_yellow),
        .ew_green     (ew_green),
        .ns_walk      (ns_walk),
        .ew_walk      (ew_walk),
        .phase        (phase),
        .phase_change (phase_change)
`ifdef PREEMPT_EN
        ,
        .preempt      (preempt),
        .preempt_dir  (preempt_dir)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic nv, input logic ev, input logic np, input logic ep);
        ns_veh = nv;
        ew_veh = ev;
        ns_ped = np;
        ew_ped = ep;
    endtask

    // Head patterns {ns r,y,g, ew r,y,g} for each phase, written out by hand.
    function automatic int expLights(input int p);
        case (p)
            0:       return 'b100_100;
            1:       return 'b001_100;
            2:       return 'b010_100;
            3:       return 'b100_100;
            4:       return 'b100_001;
            5:       return 'b100_010;
            default: return 0;
        endcase
    endfunction

    task automatic checkState(input string tag, input int p);
        checkOutput({tag, "_phase"}, int'(phase), p);
        checkOutput({tag, "_lights"},
                    int'({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}),
                    expLights(p));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (phase_change) pc_cnt++;
            if (ns_walk) ns_walk_seen++;
        end
    endtask

    task automatic waitPhaseChange(output int cycles);
        logic [2:0] p;
        p = phase;
        cycles = 0;
        while (phase == p && cycles < 200) begin
            step(1);
            cycles++;
        end
    endtask

    task automatic goToPhase(input string tag, input int target);
        int n;
        n = 0;
        while (int'(phase) != target && n < 200) begin
            step(1);
            n++;
        end
        checkOutput(tag, int'(phase), target);
    endtask

    task automatic doReset(input string tag);
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0);
        step(2);
        reset = 1'b0;
        pc_cnt = 0;
        step(2);
        checkState(tag, 1);
    endtask

    // Every cycle: one lamp per head, and at least one head red.
    always @(negedge clk) begin
        checkOutput("head_safety",
                    int'($onehot({ns_red, ns_yellow, ns_green}) &&
                         $onehot({ew_red, ew_yellow, ew_green}) && (ns_red || ew_red)),
                    1);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0);
`ifdef PREEMPT_EN
        preempt     = 1'b0;
        preempt_dir = 1'b0;
`endif
        step(2);
        checkState("reset", 0);
        checkOutput("reset_walk", int'({ns_walk, ew_walk}), 0);
        checkOutput("reset_pc", int'(phase_change), 0);

        // Release: two all-red cycles, NS green on the third, then rest.
        reset = 1'b0;
        pc_cnt = 0;
        step(1);
        checkState("ar_cycle1", 0);
        checkOutput("ar_cycle1_pc", int'(phase_change), 0);
        step(1);
        checkState("ns_entry", 1);
        checkOutput("ns_entry_pc", int'(phase_change), 1);
        pc_cnt = 0;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1);
            if (phase != 3'd1) bad++;
        end
        checkOutput("rest_pc", pc_cnt, 0);
        checkOutput("rest_phase_bad", bad, 0);

        // Gap-out: EW vehicle at timer 3, NS empty -> 8 / 4 / 2 then EW green.
        doReset("gap_entry");
        step(3);
        applyStimulus(0, 1, 0, 0);
        step(1);
        applyStimulus(0, 0, 0, 0);
        waitPhaseChange(cyc);
        checkOutput("gap_green_rest", cyc, 4);
        checkState("gap_yellow", 2);
        waitPhaseChange(cyc);
        checkOutput("gap_yellow_len", cyc, 4);
        checkState("gap_allred", 3);
        waitPhaseChange(cyc);
        checkOutput("gap_allred_len", cyc, 2);
        checkState("gap_ew_green", 4);
        checkOutput("gap_pc_count", pc_cnt, 4);

        // Max-out: NS traffic continuous, EW waiting from timer 0 -> 32 cycles.
        doReset("max_entry");
        applyStimulus(1, 1, 0, 0);
        step(1);
        applyStimulus(1, 0, 0, 0);
        waitPhaseChange(cyc);
        checkOutput("max_green_rest", cyc, 31);
        checkState("max_yellow", 2);
        applyStimulus(0, 0, 0, 0);

        // Pedestrian: EW WALK for first 6 cycles of EW green only.
        doReset("ped_entry");
        step(2);
        applyStimulus(0, 0, 0, 1);
        step(1);
        applyStimulus(0, 0, 0, 0);
        ns_walk_seen = 0;
        goToPhase("ped_to_ew", 4);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("ew_walk_t%0d", i), int'(ew_walk), 1);
            if (i == 2) applyStimulus(0, 0, 0, 1);
            step(1);
            applyStimulus(0, 0, 0, 0);
        end
        checkOutput("ew_walk_end", int'(ew_walk), 0);
        checkOutput("ns_walk_quiet", ns_walk_seen, 0);
        applyStimulus(1, 0, 0, 0);
        step(1);
        applyStimulus(0, 0, 0, 0);
        goToPhase("ped_back_ns", 1);
        checkOutput("ns_walk_unarmed", int'(ns_walk), 0);
        applyStimulus(0, 1, 0, 0);
        step(1);
        applyStimulus(0, 0, 0, 0);
        goToPhase("ped_back_ew", 4);
        checkOutput("ew_walk_not_relatched", int'(ew_walk), 0);

        // Mid-cycle reset at NS yellow timer 2 drops the pending EW request.
        doReset("mid_entry");
        applyStimulus(0, 1, 0, 0);
        step(1);
        applyStimulus(0, 0, 0, 0);
        goToPhase("mid_to_yellow", 2);
        step(2);
        reset = 1'b1;
        step(1);
        checkState("mid_reset", 0);
        checkOutput("mid_reset_pc", int'(phase_change), 0);
        reset = 1'b0;
        step(1);
        checkState("mid_allred", 0);
        step(1);
        checkState("mid_ns_green", 1);
        step(20);
        checkState("mid_rest", 1);

`ifdef PREEMPT_EN
        // Preempt toward EW at NS timer 1: yellow next, EW green 6 later, held.
        doReset("pre_entry");
        step(1);
        preempt     = 1'b1;
        preempt_dir = 1'b1;
        step(1);
        checkState("pre_yellow", 2);
        waitPhaseChange(cyc);
        checkOutput("pre_yellow_len", cyc, 4);
        waitPhaseChange(cyc);
        checkOutput("pre_allred_len", cyc, 2);
        checkState("pre_ew_green", 4);
        applyStimulus(1, 0, 0, 0);
        step(50);
        checkState("pre_hold", 4);
        preempt = 1'b0;
        applyStimulus(0, 0, 0, 0);
        step(1);
        checkState("pre_release", 5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
